mem_subsystem: RTL
==================

Name: mem_subsystem

Overview:
- Memory stage directly downstream of the multicycle control unit.
- Holds MAR and MDR and owns a single-port synchronous RAM.
- Serves the control unit's level-sensitive Read/Write strobes with a configurable wait-state latency, and feeds MDR contents back to the bus mux.
- Raises MemReady so the control unit can stall fetch, ld and st states on slow memory.

Parameters:
ADDR_WIDTH, 9, RAM address bits; MAR holds BusMuxOut[ADDR_WIDTH-1:0]; depth is 2^ADDR_WIDTH words
DATA_WIDTH, 32, word width
READ_LATENCY, 1, cycles from read acceptance to data valid (legal range 1..15)
WRITE_LATENCY, 1, cycles from write acceptance to RAM update (legal range 1..15)

Ports:
Clock  in  1  single system clock; all state updates on its rising edge
Clear  in  1  reset, synchronous active-high, sampled on rising Clock edge
BusMuxOut  in  DATA_WIDTH  bus value, source for MAR and MDR loads
MARin  in  1  load MAR from BusMuxOut
MDRin  in  1  load MDR; source selected by Read (see Behaviour)
Read  in  1  read request, level; held by the control unit until MemReady is seen
Write  in  1  write request, level; stores MDR to mem[MAR]
MDR_data  out  DATA_WIDTH  MDR contents to the bus mux (MDRout input)
MAR_addr  out  ADDR_WIDTH  current MAR value
MemReady  out  1  high while the current transaction is complete (DONE states)
Busy  out  1  high while a transaction is in the WAIT states

Behaviour:
Reset:
- Clear=1 forces MAR=0, MDR=0, read buffer=0, counter=0, MemReady=0, Busy=0 and state=IDLE.
- RAM contents are preserved.
- A write in flight is aborted: RAM is not modified.

FSM states: IDLE, RD_WAIT, RD_DONE, WR_WAIT, WR_DONE.
- IDLE:
  - Write=1: latch addr=MAR and wdata=MDR, load counter=WRITE_LATENCY, go to WR_WAIT.
  - else Read=1: latch addr=MAR, load counter=READ_LATENCY, go to RD_WAIT.
  - Write has priority when both are high. Read stays pending because it is level-sensitive and is accepted after WR_DONE exits.
- RD_WAIT: Busy=1; counter decrements each cycle. On the cycle counter==1, capture mem[addr] into the read buffer and go to RD_DONE.
- RD_DONE: MemReady=1; stay while Read=1; go to IDLE on Read=0.
- WR_WAIT: Busy=1; counter decrements. On counter==1, mem[addr]<=wdata and go to WR_DONE.
- WR_DONE: MemReady=1; stay while Write=1; go to IDLE on Write=0.

Latency:
- Read asserted at edge N (accepted in IDLE): read buffer valid and MemReady=1 from edge N+READ_LATENCY+1.
- Write follows the same timing with WRITE_LATENCY.
- Back-to-back transactions need at least one IDLE cycle, because the request must deassert.

MAR:
- Loads on MARin in any state.
- An in-flight transaction uses the address latched at acceptance, so mid-transaction MARin does not affect it.

MDR load on MDRin:
- Read=0: MDR <= BusMuxOut.
- Read=1 and state==RD_DONE: MDR <= read buffer.
- Read=1 in any other state: MDR holds. A stale or garbage load is forbidden.
- An MDRin during WR_WAIT updates MDR but not the latched wdata.

Outputs:
- MDR_data and MAR_addr are registered values, not bus pass-through.
- MemReady and Busy are decoded from the state register only. They never depend combinationally on the inputs.

Addressing:
- Out-of-range BusMuxOut bits above ADDR_WIDTH are ignored, so addresses wrap modulo 2^ADDR_WIDTH.

Test Plan:
1. Clear=1 for 2 cycles after arbitrary traffic -> MAR_addr=0, MDR_data=0, MemReady=0, Busy=0; a previously written word is still readable.
2. Write 0xDEADBEEF, READ_LATENCY=1:
   - Stimulus: BusMuxOut=0x0000_0055 with MARin, then 0xDEADBEEF with MDRin (Read=0), then Write=1.
   - Required: Busy for 1 cycle, then MemReady=1; after Write=0 the FSM returns to IDLE.
   - Read-back: Read=1 with MDRin held gives MDR_data=0xDEADBEEF only once MemReady=1.
3. READ_LATENCY=4 -> MemReady rises exactly 5 edges after Read acceptance. MDRin pulsed during RD_WAIT leaves MDR unchanged.
4. Read=1 and Write=1 together at MAR=0x10, MDR=0x12345678 -> write completes first. After Write=0, the read of 0x10 returns 0x12345678.
5. Clear asserted in WR_WAIT (WRITE_LATENCY=3) targeting 0x20, which holds 0xAAAA0000 -> state=IDLE and 0x20 still reads 0xAAAA0000.
6. BusMuxOut=0x0000_0203 with MARin -> MAR_addr=0x003 (wrap). Changing MARin mid-read does not change the returned word.

Source files
------------

// File: rtl/mem_subsystem.sv
// Memory stage behind the multicycle control unit: MAR/MDR registers, a single-port
// synchronous RAM, and a wait-state FSM that answers level-sensitive Read/Write strobes.
module mem_subsystem #(
    parameter int ADDR_WIDTH    = 9,
    parameter int DATA_WIDTH    = 32,
    parameter int READ_LATENCY  = 1,
    parameter int WRITE_LATENCY = 1
) (
    input  logic                  Clock,
    input  logic                  Clear,
    input  logic [DATA_WIDTH-1:0] BusMuxOut,
    input  logic                  MARin,
    input  logic                  MDRin,
    input  logic                  Read,
    input  logic                  Write,
    output logic [DATA_WIDTH-1:0] MDR_data,
    output logic [ADDR_WIDTH-1:0] MAR_addr,
    output logic                  MemReady,
    output logic                  Busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DONE,
        WR_WAIT,
        WR_DONE
    } state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rbuf;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  ram_we;

    // The RAM update lands on the last wait cycle; Clear on that same edge aborts it.
    assign ram_we = (state == WR_WAIT) && (cnt == 4'd1) && !Clear;

    // NOTE: the RAM array has no reset branch so it maps onto a real memory macro
    // and keeps its contents across Clear.
    always_ff @(posedge Clock) begin
        if (ram_we)
            mem[addr] <= wdata;
    end

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state    <= IDLE;
            cnt      <= '0;
            addr     <= '0;
            wdata    <= '0;
            rbuf     <= '0;
            MAR_addr <= '0;
            MDR_data <= '0;
            MemReady <= 1'b0;
            Busy     <= 1'b0;
        end else begin
            if (MARin)
                MAR_addr <= BusMuxOut[ADDR_WIDTH-1:0];

            // With Read high, MDR may only take a completed read word, never the bus.
            if (MDRin) begin
                if (!Read)
                    MDR_data <= BusMuxOut;
                else if (state == RD_DONE)
                    MDR_data <= rbuf;
            end

            // Status flags follow the state register one edge later.
            MemReady <= (state == RD_DONE) || (state == WR_DONE);
            Busy     <= (state == RD_WAIT) || (state == WR_WAIT);

            case (state)
                IDLE: begin
                    if (Write) begin
                        addr  <= MAR_addr;
                        wdata <= MDR_data;
                        cnt   <= 4'(WRITE_LATENCY);
                        state <= WR_WAIT;
                    end else if (Read) begin
                        addr  <= MAR_addr;
                        cnt   <= 4'(READ_LATENCY);
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        rbuf  <= mem[addr];
                        state <= RD_DONE;
                    end
                end
                RD_DONE: begin
                    if (!Read)
                        state <= IDLE;
                end
                WR_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= WR_DONE;
                end
                WR_DONE: begin
                    if (!Write)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
